// File: rtl/prog_imem.sv
// prog_imem: run-time loadable instruction memory for the single-cycle CPU.
// A program is written through a valid/ready load port. Instructions are
// fetched combinationally once the memory reaches RUN.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   AddrIn           - fetch address from PC (word index or byte address)
//   InsOut           - fetched instruction, NOP_INS when gated or faulting
//   FetchFault       - in RUN and the address is out of range or misaligned
//   Run              - memory holds a program; releases the CPU's PC
//   LdStart          - pulse that starts or restarts a load
//   LdValid/LdData   - program word handshake (accepted when LdReady)
//   LdLast           - marks the final program word
//   LdReady          - a load word can be accepted this cycle
//   LdCount          - words written by the current or most recent load
module prog_imem #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_INS   = '0,
  parameter int unsigned       CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AddrIn,
  output logic [DATA_W-1:0] InsOut,
  output logic              FetchFault,
  output logic              Run,
  input  logic              LdStart,
  input  logic              LdValid,
  input  logic [DATA_W-1:0] LdData,
  input  logic              LdLast,
  output logic              LdReady,
  output logic [CNT_W-1:0]  LdCount
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_WP = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wp_q, wp_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];

  logic [ADDR_W-1:0]  idx_full;
  logic               fault;

  // LdCount always equals the write pointer: both clear on LdStart and
  // both advance to wp+1 on every accepted word, so one register serves.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (LdStart) begin
          state_d = S_LOAD;
          wp_d    = '0;
        end
      end
      S_LOAD: begin
        // LdStart outranks a word offered in the same cycle.
        if (LdStart) begin
          wp_d = '0;
        end else if (LdValid) begin
          mem_d[wp_q[IDX_W-1:0]] = LdData;
          wp_d = wp_q + CNT_W'(1);
          if (LdLast || (wp_q == LAST_WP)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (LdStart) begin
          state_d = S_LOAD;
          wp_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_INS;
      end
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      mem_q   <= mem_d;
    end
  end

  // Range check uses the full address so out-of-range indices never alias
  // onto low entries through truncation.
  always_comb begin
    idx_full   = BYTE_ADDR ? (AddrIn >> 2) : AddrIn;
    fault      = ({1'b0, idx_full} >= DEPTH_CMP) ||
                 (BYTE_ADDR && (AddrIn[1:0] != 2'b00));
    Run        = (state_q == S_RUN);
    LdReady    = (state_q == S_LOAD);
    LdCount    = wp_q;
    FetchFault = Run && fault;
    InsOut     = (Run && !fault) ? mem_q[idx_full[IDX_W-1:0]] : NOP_INS;
  end

endmodule

// File: tb/tb_prog_imem.sv
module tb_prog_imem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: DEPTH=32, word addressing.
  logic [31:0] a_addr = '0, a_ins, a_data = '0;
  logic        a_ff, a_run, a_start = 1'b0, a_valid = 1'b0, a_last = 1'b0, a_ready;
  logic [5:0]  a_cnt;
  // Instance b: DEPTH=4, byte addressing.
  logic [31:0] b_addr = '0, b_ins, b_data = '0;
  logic        b_ff, b_run, b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_ready;
  logic [2:0]  b_cnt;

  prog_imem u_a (
    .clk(clk), .rst(rst), .AddrIn(a_addr), .InsOut(a_ins), .FetchFault(a_ff),
    .Run(a_run), .LdStart(a_start), .LdValid(a_valid), .LdData(a_data),
    .LdLast(a_last), .LdReady(a_ready), .LdCount(a_cnt)
  );

  prog_imem #(.DEPTH(4), .BYTE_ADDR(1'b1)) u_b (
    .clk(clk), .rst(rst), .AddrIn(b_addr), .InsOut(b_ins), .FetchFault(b_ff),
    .Run(b_run), .LdStart(b_start), .LdValid(b_valid), .LdData(b_data),
    .LdLast(b_last), .LdReady(b_ready), .LdCount(b_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Spec-level model: per instance, a program image, a word count and a
  // mode (0 idle, 1 loading, 2 running).
  logic [31:0] mm [2][32];
  int          mc [2];
  int          ms [2];

  task automatic mstep(int k, bit start, bit valid, bit last, logic [31:0] data, int depth);
    if (rst) begin
      ms[k] = 0;
      mc[k] = 0;
      for (int i = 0; i < 32; i++) mm[k][i] = '0;
    end else if (start) begin
      ms[k] = 1;
      mc[k] = 0;
    end else if (ms[k] == 1 && valid) begin
      mm[k][mc[k]] = data;
      mc[k]++;
      if (last || mc[k] == depth) ms[k] = 2;
    end
  endtask

  always @(posedge clk) begin
    mstep(0, a_start, a_valid, a_last, a_data, 32);
    mstep(1, b_start, b_valid, b_last, b_data, 4);
  end

  task automatic cmp_inst(int k, int depth, bit byt, logic run, logic rdy,
                          logic [63:0] cnt, logic [31:0] ins, logic ff, logic [31:0] addr);
    logic [31:0] idx;
    logic [31:0] ei;
    bit f;
    bit r;
    idx = byt ? (addr >> 2) : addr;
    f   = (idx >= 32'(depth)) || (byt && addr[1:0] != 2'b00);
    r   = (ms[k] == 2);
    ei  = (r && !f) ? mm[k][idx[4:0]] : '0;
    chk($sformatf("run[%0d]", k), run, r);
    chk($sformatf("ready[%0d]", k), rdy, ms[k] == 1);
    chk($sformatf("count[%0d]", k), cnt, mc[k]);
    chk($sformatf("ins[%0d]@%0h", k, addr), ins, ei);
    chk($sformatf("fault[%0d]@%0h", k, addr), ff, r && f);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, 32, 1'b0, a_run, a_ready, a_cnt, a_ins, a_ff, a_addr);
      cmp_inst(1, 4, 1'b1, b_run, b_ready, b_cnt, b_ins, b_ff, b_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(bit s, bit v, bit l, logic [31:0] d);
    a_start = s; a_valid = v; a_last = l; a_data = d;
  endtask

  task automatic b_drive(bit s, bit v, bit l, logic [31:0] d);
    b_start = s; b_valid = v; b_last = l; b_data = d;
  endtask

  task automatic look_a(logic [31:0] addr, logic [31:0] ins, bit ff);
    tick();
    a_addr = addr;
    #1;
    chk($sformatf("lit_a_ins@%0h", addr), a_ins, ins);
    chk($sformatf("lit_a_fault@%0h", addr), a_ff, ff);
  endtask

  task automatic look_b(logic [31:0] addr, logic [31:0] ins, bit ff);
    tick();
    b_addr = addr;
    #1;
    chk($sformatf("lit_b_ins@%0h", addr), b_ins, ins);
    chk($sformatf("lit_b_fault@%0h", addr), b_ff, ff);
  endtask

  logic [31:0] wa [10] = '{32'h8e, 32'h10e, 32'h18e, 32'h20e, 32'h28e,
                           32'h30e, 32'h38e, 32'h40e, 32'h48e, 32'h12};

  initial begin
    // Reset for two cycles.
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run", a_run, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_count", a_cnt, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      a_addr = 32'(i);
      #1;
      chk($sformatf("rst_ins@%0d", i), a_ins, 0);
      chk($sformatf("rst_fault@%0d", i), a_ff, 0);
    end

    // Normal 10-word load, word addressing.
    tick(); a_drive(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      tick(); a_drive(0, 1, i == 9, wa[i]);
      if (i == 0) chk("load_ready", a_ready, 1);
    end
    tick(); a_drive(0, 1, 0, 32'hBAD0_0001);  // offered in RUN: ignored
    chk("load_run", a_run, 1);
    chk("load_ready_off", a_ready, 0);
    chk("load_count", a_cnt, 10);
    tick(); a_drive(0, 0, 0, '0);
    chk("run_ignore_count", a_cnt, 10);
    look_a(0, 32'h8e, 0);
    look_a(9, 32'h12, 0);
    look_a(10, 32'h0, 0);
    look_a(32, 32'h0, 1);

    // Full array on DEPTH=4 without LdLast: A..D stored, E,F refused.
    tick(); b_drive(1, 0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      tick(); b_drive(0, 1, 0, 32'(10 + i));
      if (i >= 4) begin
        chk("full_ready_off", b_ready, 0);
        chk("full_run", b_run, 1);
      end
    end
    tick(); b_drive(0, 0, 0, '0);
    chk("full_count", b_cnt, 4);
    look_b(0, 32'hA, 0);
    look_b(4, 32'hB, 0);
    look_b(8, 32'hC, 0);
    look_b(12, 32'hD, 0);
    look_b(16, 32'h0, 1);

    // Byte addressing after loading 0x11, 0x22.
    tick(); b_drive(1, 0, 0, '0);
    tick(); b_drive(0, 1, 0, 32'h11);
    tick(); b_drive(0, 1, 1, 32'h22);
    tick(); b_drive(0, 0, 0, '0);
    chk("byte_run", b_run, 1);
    chk("byte_count", b_cnt, 2);
    look_b(4, 32'h22, 0);
    look_b(2, 32'h0, 1);
    look_b(32'h80, 32'h0, 1);
    look_b(8, 32'hC, 0);   // not rewritten: keeps old contents
    look_b(0, 32'h11, 0);

    // Restart while a word is offered.
    tick(); a_drive(1, 0, 0, '0);
    tick(); a_drive(0, 1, 0, 32'h1001);
    tick(); a_drive(0, 1, 0, 32'h1002);
    tick(); a_drive(0, 1, 0, 32'h1003);
    tick(); a_drive(1, 1, 0, 32'hDEAD);
    tick(); a_drive(0, 1, 1, 32'hBEEF);
    chk("restart_count0", a_cnt, 0);
    tick(); a_drive(0, 0, 0, '0);
    chk("restart_run", a_run, 1);
    chk("restart_count", a_cnt, 1);
    look_a(0, 32'hBEEF, 0);
    look_a(1, 32'h1002, 0);
    look_a(2, 32'h1003, 0);
    look_a(3, 32'h20e, 0);

    // Reset mid-load after 2 of 5 words.
    tick(); a_drive(1, 0, 0, '0);
    tick(); a_drive(0, 1, 0, 32'h2001);
    tick(); a_drive(0, 1, 0, 32'h2002);
    tick(); a_drive(0, 1, 0, 32'h2003); rst = 1'b1;
    tick(); a_drive(0, 0, 0, '0); rst = 1'b0;
    chk("mid_rst_run", a_run, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_b_run", b_run, 0);
    look_a(0, 32'h0, 0);
    look_a(40, 32'h0, 0);
    tick(); a_drive(1, 0, 0, '0);
    tick(); a_drive(0, 1, 1, 32'h3003);
    tick(); a_drive(0, 0, 0, '0);
    chk("reload_count", a_cnt, 1);
    look_a(0, 32'h3003, 0);
    look_a(1, 32'h0, 0);   // cleared by the reset
    look_a(2, 32'h0, 0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
